pipelined_sat_addsub: RTL and testbench

//  Parametrised, pipelined add/subtract unit built from 4-bit CLA groups, with

---
 rtl/pipelined_sat_addsub.sv | 184 ++++++++++++++++++
 tb/tb_pipelined_sat_addsub.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_sat_addsub.sv
// pipelined_sat_addsub
//   Pipelined two's-complement add/subtract unit. Each of the STAGES pipeline
//   stages adds one WIDTH/STAGES-bit slice using 4-bit CLA groups with
//   group-level lookahead. The slice carry is registered into the next stage.
//   The final stage applies optional signed saturation and produces the
//   N/Z/V/C flags. A valid/ready handshake with backpressure stalls all stages
//   together. Latency and capacity are both STAGES beats.
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   in_valid / in_ready  operand handshake (in_ready is combinational)
//   a, b, cin            operands and carry-in (borrow-in when sub=1)
//   sub, sat             1 = A-B-cin; 1 = saturate on signed overflow
//   out_valid/out_ready  result handshake
//   result               sum/difference after optional saturation
//   flag_n/z/v/c         sign, zero, raw overflow, raw carry (sub: 1 = no borrow)
module pipelined_sat_addsub #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   input  logic             sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             flag_n,
   output logic             flag_z,
   output logic             flag_v,
   output logic             flag_c
);

   localparam int SW = WIDTH / STAGES;   // bits resolved per stage
   localparam int NG = SW / 4;           // 4-bit CLA groups per stage

   // Slice adder. Returns {carry out, carry into slice MSB, sum}.
   // Group generate/propagate feed a lookahead chain for the group carries,
   // and the bit carries inside each group are expanded from the group carry-in.
   function automatic logic [SW+1:0] cla_slice(input logic [SW-1:0] x,
                                                input logic [SW-1:0] y,
                                                input logic          ci);
      logic [SW-1:0] g, p;
      logic [SW:0]   c;
      logic [NG:0]   gc;
      logic [NG-1:0] gg, gp;
      g  = x & y;
      p  = x ^ y;
      c  = '0;
      gc = '0;
      gg = '0;
      gp = '0;
      for (int j = 0; j < NG; j++) begin
         gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
         gp[j] = &p[4*j +: 4];
      end
      gc[0] = ci;
      for (int j = 0; j < NG; j++) gc[j+1] = gg[j] | (gp[j] & gc[j]);
      for (int j = 0; j < NG; j++) begin
         c[4*j]   = gc[j];
         c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
         c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
         c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                  | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
      end
      c[SW] = gc[NG];
      return {c[SW], c[SW-1], p ^ c[SW-1:0]};
   endfunction

   logic [STAGES:1] vld_q;       // vld_q[j]: valid of the register after stage j-1
   logic             advance;
   logic [WIDTH-1:0] b_eff;
   logic             ci_eff;

   // Final-stage combinational outputs
   logic             fin_vld;
   logic [WIDTH-1:0] fin_sum;
   logic             fin_cout, fin_cmsb, fin_amsb, fin_sat;

   logic [WIDTH-1:0] result_d, result_q;
   logic             v_d;
   logic             n_q, z_q, v_q, c_q;

   // Every stage moves in lockstep; only a stalled head beat blocks the pipe.
   assign advance  = ~vld_q[STAGES] | out_ready;
   assign in_ready = advance;

   assign b_eff  = sub ? ~b : b;
   assign ci_eff = sub ? ~cin : cin;

   for (genvar k = 0; k < STAGES; k++) begin : stg
      localparam int REM = WIDTH - k*SW;   // operand bits still unprocessed at stage k

      logic [REM-1:0]        a_rem, b_rem;
      logic                  ci_s, sat_s, v_in;
      logic [SW+1:0]         r;
      logic [(k+1)*SW-1:0]   s_new;        // sum bits resolved so far, including this slice

      assign r = cla_slice(a_rem[SW-1:0], b_rem[SW-1:0], ci_s);

      if (k == 0) begin : src
         assign a_rem = a;
         assign b_rem = b_eff;
         assign ci_s  = ci_eff;
         assign sat_s = sat;
         assign v_in  = in_valid;
         assign s_new = r[SW-1:0];
      end else begin : src
         assign a_rem = stg[k-1].pipe.a_hi_q;
         assign b_rem = stg[k-1].pipe.b_hi_q;
         assign ci_s  = stg[k-1].pipe.cy_q;
         assign sat_s = stg[k-1].pipe.sat_q;
         assign v_in  = vld_q[k];
         assign s_new = {r[SW-1:0], stg[k-1].pipe.s_q};
      end

      if (k < STAGES-1) begin : pipe
         // Only the operand bits later stages still need travel with the beat.
         logic [REM-SW-1:0]   a_hi_q, b_hi_q;
         logic [(k+1)*SW-1:0] s_q;
         logic                cy_q, sat_q;

         always_ff @(posedge clk) begin
            if (advance && v_in) begin
               a_hi_q <= a_rem[REM-1:SW];
               b_hi_q <= b_rem[REM-1:SW];
               s_q    <= s_new;
               cy_q   <= r[SW+1];
               sat_q  <= sat_s;
            end
         end
      end else begin : fin
         assign fin_vld  = v_in;
         assign fin_sum  = s_new;
         assign fin_cout = r[SW+1];
         assign fin_cmsb = r[SW];
         assign fin_amsb = a_rem[SW-1];   // a[WIDTH-1] selects the saturation rail
         assign fin_sat  = sat_s;
      end
   end

   always_comb begin
      v_d      = fin_cout ^ fin_cmsb;
      result_d = fin_sum;
      if (fin_sat && v_d)
         result_d = fin_amsb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q    <= '0;
         result_q <= '0;
         n_q      <= 1'b0;
         z_q      <= 1'b0;
         v_q      <= 1'b0;
         c_q      <= 1'b0;
      end else if (advance) begin
         vld_q[1] <= in_valid;
         for (int j = 2; j <= STAGES; j++) vld_q[j] <= vld_q[j-1];
         // Bubbles leave the output registers untouched.
         if (fin_vld) begin
            result_q <= result_d;
            n_q      <= result_d[WIDTH-1];
            z_q      <= ~|result_d;
            v_q      <= v_d;
            c_q      <= fin_cout;
         end
      end
   end

   assign out_valid = vld_q[STAGES];
   assign result    = result_q;
   assign flag_n    = n_q;
   assign flag_z    = z_q;
   assign flag_v    = v_q;
   assign flag_c    = c_q;

endmodule

// File: tb/tb_pipelined_sat_addsub.sv
module tb_pipelined_sat_addsub;

   logic        clk, rst, in_valid, in_ready, cin, sub, sat, out_valid, out_ready;
   logic [15:0] a, b, result;
   logic        flag_n, flag_z, flag_v, flag_c;
   logic [3:0]  flags;

   assign flags = {flag_n, flag_z, flag_v, flag_c};

   pipelined_sat_addsub #(.WIDTH(16), .STAGES(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .sat(sat),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v), .flag_c(flag_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] res;
      logic [3:0]  nzvc;
   } exp_t;

   typedef struct {
      logic [15:0] a, b;
      logic        cin, sub, sat;
      logic [15:0] res;
      logic [3:0]  nzvc;
   } vec_t;

   int   tests = 0;
   int   fails = 0;
   int   n_out = 0;
   exp_t sb[$];
   logic acc;
   logic hold_chk = 1'b0;
   logic [15:0] hold_res;
   logic [3:0]  hold_flg;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: signed/unsigned integer arithmetic on the operand values.
   function automatic exp_t model(input logic [15:0] xa, input logic [15:0] xb,
                                  input logic ci, input logic sb_op, input logic st);
      exp_t e;
      int sa, sbv, ua, ub, ideal;
      logic v, c;
      logic [15:0] r;
      sa  = int'($signed(xa));
      sbv = int'($signed(xb));
      ua  = int'(xa);
      ub  = int'(xb);
      ideal = sb_op ? (sa - sbv - int'(ci)) : (sa + sbv + int'(ci));
      v = (ideal > 32767) || (ideal < -32768);
      c = sb_op ? (ua >= ub + int'(ci)) : (ua + ub + int'(ci) > 65535);
      r = ideal[15:0];
      if (st && v) r = (ideal > 0) ? 16'h7FFF : 16'h8000;
      e.res  = r;
      e.nzvc = {r[15], r == 16'h0, v, c};
      return e;
   endfunction

   // One clock: bookkeeping on the falling edge, then on to just after the rising edge.
   task automatic step();
      exp_t e;
      @(negedge clk);
      if (hold_chk) begin
         chk("hold_result", result, hold_res);
         chk("hold_flags", flags, hold_flg);
      end
      hold_chk = out_valid && !out_ready && !rst;
      hold_res = result;
      hold_flg = flags;
      if (out_valid && out_ready && !rst) begin
         if (sb.size() == 0) begin
            chk("spurious_out", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("sb_result", result, e.res);
            chk("sb_flags", flags, e.nzvc);
            n_out++;
         end
      end
      acc = in_valid && in_ready && !rst;
      if (acc) sb.push_back(model(a, b, cin, sub, sat));
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] pick();
      logic [15:0] corners [4] = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000};
      if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
      return 16'($urandom);
   endfunction

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t vt [12];
      logic [15:0] sa_v [4];
      logic [15:0] sb_v [4];
      int idx, n0, nacc;

      vt[0]  = '{16'h7FFF, 16'h0001, 0, 0, 1, 16'h7FFF, 4'b0010};
      vt[1]  = '{16'h7FFF, 16'h0001, 0, 0, 0, 16'h8000, 4'b1010};
      vt[2]  = '{16'h8000, 16'h0001, 0, 1, 1, 16'h8000, 4'b1011};
      vt[3]  = '{16'hFFFF, 16'h0001, 0, 0, 0, 16'h0000, 4'b0101};
      vt[4]  = '{16'h1234, 16'h1234, 0, 1, 0, 16'h0000, 4'b0101};
      vt[5]  = '{16'h0001, 16'h0001, 1, 0, 0, 16'h0003, 4'b0000};
      vt[6]  = '{16'h0000, 16'h0001, 0, 1, 0, 16'hFFFF, 4'b1000};
      vt[7]  = '{16'h0005, 16'h0002, 1, 1, 0, 16'h0002, 4'b0001};
      vt[8]  = '{16'h8000, 16'h8000, 0, 0, 1, 16'h8000, 4'b1011};
      vt[9]  = '{16'h8000, 16'h8000, 0, 0, 0, 16'h0000, 4'b0111};
      vt[10] = '{16'h00FF, 16'h0001, 0, 0, 0, 16'h0100, 4'b0000};
      vt[11] = '{16'h7FFF, 16'hFFFF, 0, 1, 1, 16'h7FFF, 4'b0010};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0; sat = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_flags", flags, 0);
      chk("rst_in_ready", in_ready, 1);

      // Directed vectors, one at a time, with latency check
      for (int i = 0; i < 12; i++) begin
         a = vt[i].a; b = vt[i].b; cin = vt[i].cin; sub = vt[i].sub; sat = vt[i].sat;
         in_valid = 1'b1;
         step();
         chk($sformatf("vec%0d_accept", i), acc, 1);
         in_valid = 1'b0;
         chk($sformatf("vec%0d_lat_early", i), out_valid, 0);
         step();
         chk($sformatf("vec%0d_out_valid", i), out_valid, 1);
         chk($sformatf("vec%0d_result", i), result, vt[i].res);
         chk($sformatf("vec%0d_flags", i), flags, vt[i].nzvc);
         step();
      end

      // Backpressure: 4 beats offered while out_ready=0 for 5 cycles
      sa_v = '{16'h1111, 16'h7FF0, 16'h8000, 16'hFFFF};
      sb_v = '{16'h2222, 16'h0100, 16'h0001, 16'h0001};
      idx = 0; n0 = n_out;
      cin = 1'b0; sub = 1'b0; sat = 1'b1;
      for (int cyc = 0; cyc < 40 && (idx < 4 || sb.size() > 0); cyc++) begin
         out_ready = (cyc >= 5);
         in_valid  = (idx < 4);
         if (idx < 4) begin a = sa_v[idx]; b = sb_v[idx]; end
         if (cyc >= 2 && cyc < 5) begin
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_head_result", result, 16'h3333);
         end
         if (cyc == 4) chk("stall_accepted", idx, 2);
         step();
         if (acc) idx++;
      end
      in_valid = 1'b0;
      chk("stall_all_accepted", idx, 4);
      chk("stall_all_emitted", n_out - n0, 4);

      // Full pipe streaming: one retire and one accept per cycle
      out_ready = 1'b1; nacc = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         a = pick(); b = pick(); cin = 1'($urandom); sub = 1'($urandom); sat = 1'($urandom);
         in_valid = 1'b1;
         if (cyc >= 2) begin
            chk("stream_out_valid", out_valid, 1);
            chk("stream_in_ready", in_ready, 1);
         end
         step();
         if (acc) nacc++;
      end
      in_valid = 1'b0;
      chk("stream_accepts", nacc, 12);
      for (int k = 0; k < 5 && sb.size() > 0; k++) step();
      chk("stream_drained", sb.size(), 0);

      // Reset with two beats in flight
      out_ready = 1'b0; nacc = 0;
      a = 16'h0042; b = 16'h0001; sub = 1'b0; sat = 1'b0; cin = 1'b0;
      in_valid = 1'b1;
      step(); if (acc) nacc++;
      a = 16'h0100;
      step(); if (acc) nacc++;
      chk("flush_two_in_flight", nacc, 2);
      in_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      sb.delete();
      chk("flush_out_valid", out_valid, 0);
      chk("flush_result", result, 0);
      chk("flush_flags", flags, 0);
      chk("flush_in_ready", in_ready, 1);
      out_ready = 1'b1; n0 = n_out;
      repeat (6) step();
      chk("flush_no_stale", n_out - n0, 0);

      // Random traffic against the scoreboard
      for (int cyc = 0; cyc < 400; cyc++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 7);
         a = pick(); b = pick();
         cin = 1'($urandom); sub = 1'($urandom); sat = 1'($urandom);
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 20 && sb.size() > 0; k++) step();
      chk("random_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
